// File: rtl/median_pkg.sv
// median_pkg: shared widths, pixel/index types and border test
// for the median_3x3 frame filter.
package median_pkg;

  localparam int BIT_WIDTH_DEF  = 8;
  localparam int ADDR_WIDTH_DEF = 14;
  localparam int IMG_W_DEF      = 100;
  localparam int IMG_H_DEF      = 100;

  typedef logic [BIT_WIDTH_DEF-1:0]  pix_t;
  typedef logic [ADDR_WIDTH_DEF-1:0] idx_t;

  // Stage-1 control bundle that travels alongside the window data.
  typedef struct packed {
    logic vld;
    logic brd;
    idx_t idx;
  } s1_t;

  function automatic logic is_border(idx_t index);
    int unsigned r;
    int unsigned c;
    r = int'(index) / IMG_W_DEF;
    c = int'(index) % IMG_W_DEF;
    return (r == 0) || (r == IMG_H_DEF - 1) ||
           (c == 0) || (c == IMG_W_DEF - 1);
  endfunction

endpackage

// File: rtl/median9_sort.sv
// median9_sort: combinational median of nine pixels using a
// 19 compare-exchange network; output is the middle element.
module median9_sort
  import median_pkg::*;
#(
  parameter int BIT_WIDTH = BIT_WIDTH_DEF
) (
  input  logic [BIT_WIDTH-1:0] win_i [9],
  output logic [BIT_WIDTH-1:0] med_o
);

  // Each pair (LO,HI) leaves the smaller value at LO.
  localparam int LO [19] = '{
    1, 4, 7, 0, 3, 6, 1, 4, 7, 0,
    5, 4, 3, 1, 2, 4, 4, 6, 4
  };
  localparam int HI [19] = '{
    2, 5, 8, 1, 4, 7, 2, 5, 8, 3,
    8, 7, 6, 4, 5, 7, 2, 4, 2
  };

  logic [BIT_WIDTH-1:0] s [9];
  logic [BIT_WIDTH-1:0] t;

  always_comb begin
    s = win_i;
    t = '0;
    for (int k = 0; k < 19; k++) begin
      if (s[LO[k]] > s[HI[k]]) begin
        t        = s[LO[k]];
        s[LO[k]] = s[HI[k]];
        s[HI[k]] = t;
      end
    end
    med_o = s[4];
  end

endmodule

// File: rtl/median_3x3.sv
// median_3x3: raster-scan 3x3 median filter over an internal frame.
// Build option: MEDIAN_BORDER_ZERO_EN makes border outputs 0x00.
module median_3x3
  import median_pkg::*;
#(
  parameter int BIT_WIDTH  = BIT_WIDTH_DEF,
  parameter int IMG_W      = IMG_W_DEF,
  parameter int IMG_H      = IMG_H_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [BIT_WIDTH-1:0]  wr_data,
  input  logic                  header_done,
  input  logic                  domedian,
  output logic [BIT_WIDTH-1:0]  data_out,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  median_done
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NPIX - 1);
  localparam logic [ADDR_WIDTH-1:0] ENDV = ADDR_WIDTH'(NPIX);

  logic [BIT_WIDTH-1:0]  mem_q [NPIX];
  logic [BIT_WIDTH-1:0]  win_q [9];
  logic [ADDR_WIDTH-1:0] raddr [9];

  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  s1_t                   s1_q, s1_d;
  logic                  run;
  logic                  issue;

  logic [BIT_WIDTH-1:0]  med;
  logic [BIT_WIDTH-1:0]  pix;
  logic [BIT_WIDTH-1:0]  dout_q, dout_d;
  logic                  vld_q;
  logic [ADDR_WIDTH-1:0] oidx_q, oidx_d;
  logic                  done_q, done_d;

  assign run   = header_done & domedian;
  assign issue = run & (cnt_q != ENDV);

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != ENDV) cnt_d = cnt_q + 1'b1;
  end

  // Neighbour addresses clamp into the frame so no read goes out of range.
  always_comb begin
    int a;
    a = 0;
    for (int k = 0; k < 9; k++) begin
      a = int'(cnt_q) + (k / 3 - 1) * IMG_W + (k % 3 - 1);
      if (a < 0) a = 0;
      else if (a > NPIX - 1) a = NPIX - 1;
      raddr[k] = ADDR_WIDTH'(a);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem_q[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 9; k++) begin
      win_q[k] <= mem_q[raddr[k]];
    end
  end

  always_comb begin
    s1_d.vld = issue;
    s1_d.brd = is_border(cnt_q);
    s1_d.idx = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt_q <= '0;
      s1_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      s1_q  <= s1_d;
    end
  end

  median9_sort #(
    .BIT_WIDTH (BIT_WIDTH)
  ) u_sort (
    .win_i (win_q),
    .med_o (med)
  );

  always_comb begin
`ifdef MEDIAN_BORDER_ZERO_EN
    pix = s1_q.brd ? '0 : med;
`else
    pix = s1_q.brd ? win_q[4] : med;
`endif
    dout_d = s1_q.vld ? pix : '0;
    oidx_d = s1_q.vld ? s1_q.idx : '0;
    done_d = done_q | (s1_q.vld & (s1_q.idx == LAST));
  end

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      dout_q <= '0;
      vld_q  <= 1'b0;
      oidx_q <= '0;
      done_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
      vld_q  <= s1_q.vld;
      oidx_q <= oidx_d;
      done_q <= done_d;
    end
  end

  assign data_out    = dout_q;
  assign out_valid   = vld_q;
  assign out_index   = oidx_q;
  assign median_done = done_q;

endmodule

// File: tb/tb_median_3x3.sv
// tb_median_3x3: random and directed frames checked against a
// sort-based reference median of the testbench's own frame copy.
module tb_median_3x3;

  localparam int W = 100;
  localparam int H = 100;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [13:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        header_done = 1'b0;
  logic        domedian = 1'b0;
  logic [7:0]  data_out;
  logic        out_valid;
  logic [13:0] out_index;
  logic        median_done;

  int n_cmp = 0;
  int n_err = 0;
  int img [N];
  int got [N];

  median_3x3 dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .header_done (header_done),
    .domedian    (domedian),
    .data_out    (data_out),
    .out_valid   (out_valid),
    .out_index   (out_index),
    .median_done (median_done)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] g, logic [31:0] e);
    n_cmp++;
    if (g !== e) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, g, e);
    end
  endtask

  function automatic int ref_px(int idx);
    int r;
    int c;
    int q[$];
    r = idx / W;
    c = idx % W;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) begin
`ifdef MEDIAN_BORDER_ZERO_EN
      return 0;
`else
      return img[idx];
`endif
    end
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        q.push_back(img[(r + dr) * W + c + dc]);
    q.sort();
    return q[4];
  endfunction

  task automatic wr(int a, int v);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = 14'(a);
    wr_data = 8'(v);
    img[a]  = v;
  endtask

  task automatic wr_end();
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Full scan from a fresh start; every output checked in order.
  task automatic run_frame();
    int e = 0;
    int cyc = 0;
    int first = -1;
    domedian = 1'b1;
    while (e < N && cyc < N + 20) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        if (first < 0) first = cyc;
        check("idx", 32'(out_index), e);
        got[e] = int'(data_out);
        check("pix", 32'(data_out), ref_px(e));
        check("done", 32'(median_done), 32'(e == N - 1));
        e++;
      end
    end
    check("latency", first, 2);
    check("count", e, N);
    repeat (2) begin
      @(negedge clk);
      check("hold_v", 32'(out_valid), 0);
      check("hold_done", 32'(median_done), 1);
    end
    domedian = 1'b0;
    @(negedge clk);
    check("drop_done", 32'(median_done), 0);
    check("drop_v", 32'(out_valid), 0);
  endtask

  initial begin
    int e;
    int cyc;
    int first;
    int k;

    repeat (3) @(negedge clk);
    check("rst_v", 32'(out_valid), 0);
    check("rst_d", 32'(data_out), 0);
    check("rst_i", 32'(out_index), 0);
    check("rst_done", 32'(median_done), 0);
    rst = 1'b0;

    // Zero frame with an impulse and a graded 3x3 window.
    for (int i = 0; i < N; i++) wr(i, 0);
    wr(50 * W + 50, 255);
    k = 0;
    for (int r = 9; r <= 11; r++)
      for (int c = 9; c <= 11; c++) begin
        wr(r * W + c, 9 - k);
        k++;
      end
    wr_end();

    domedian = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("no_hdr", 32'(out_valid), 0);
    end
    domedian = 1'b0;
    header_done = 1'b1;
    @(negedge clk);

    run_frame();
    check("win1010", got[1010], 5);
    check("imp5050", got[5050], 0);

    // Stop after 5000 outputs, then restart.
    domedian = 1'b1;
    e = 0;
    cyc = 0;
    while (e < 5000 && cyc < 5100) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        check("p_idx", 32'(out_index), e);
        e++;
      end
    end
    check("p_count", e, 5000);
    domedian = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stop_v", 32'(out_valid), 0);
      check("stop_done", 32'(median_done), 0);
    end
    domedian = 1'b1;
    e = 0;
    cyc = 0;
    first = -1;
    while (e < 1500 && cyc < 1600) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        if (first < 0) first = cyc;
        check("r_idx", 32'(out_index), e);
        check("r_pix", 32'(data_out), ref_px(e));
        e++;
      end
    end
    check("r_latency", first, 2);

    // Reset mid-run with a write that must be ignored.
    rst     = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 14'd1010;
    wr_data = 8'hEE;
    @(negedge clk);
    check("mrst_v", 32'(out_valid), 0);
    check("mrst_d", 32'(data_out), 0);
    check("mrst_i", 32'(out_index), 0);
    check("mrst_done", 32'(median_done), 0);
    rst   = 1'b0;
    wr_en = 1'b0;
    run_frame();
    check("rstwr1010", got[1010], 5);

    // Ramp frame with a random band in the middle rows.
    for (int i = 0; i < N; i++) wr(i, i % 256);
    for (int i = 40 * W; i < 60 * W; i++)
      wr(i, int'($urandom_range(0, 255)));
    wr_end();
    run_frame();
`ifdef MEDIAN_BORDER_ZERO_EN
    check("ramp0", got[0], 0);
    check("ramp99", got[99], 0);
`else
    check("ramp0", got[0], 0);
    check("ramp99", got[99], 8'h63);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
